reg_wb_ctrl: RTL
================

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 2, load-result queue depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data  input  1/3/8  ALU result; always accepted, no ready.
REQ-005 SHALL have ports ld_valid/ld_rd/ld_data  input  1/3/8  load-unit result offer.
REQ-006 SHALL have port ld_ready  output  1  load queue can accept this cycle.
REQ-007 SHALL have ports iss_valid/iss_rd  input  1/3  instruction issued targeting iss_rd.
REQ-008 SHALL have ports rd_addr_a/rd_addr_b  input  3/3  register-file read addresses under lookup.
REQ-009 SHALL have ports busy_a/busy_b  output  1/1  addressed register has a pending write.
REQ-010 SHALL have ports fwd_a_valid/fwd_a_data, fwd_b_valid/fwd_b_data  output  1/8 each  bypass of current write.
REQ-011 SHALL have ports wr_en/wr_addr/wr_data  output  1/3/8  register-file write port (write, address_of_d, dataIn).
REQ-012 SHALL have port ldq_count  output  clog2(LDQ_DEPTH)+1  load queue occupancy.

Function
REQ-013 SHALL register wr_en/wr_addr/wr_data; at most one write per cycle.
REQ-014 SHALL give ALU priority: alu_valid with alu_rd!=0 in cycle N -> wr_en=1, wr_addr=alu_rd, wr_data=alu_data in cycle N+1.
REQ-015 SHALL accept a load when ld_valid && ld_ready, pushing {ld_rd, ld_data} to the queue tail.
REQ-016 SHALL drive ld_ready = (ldq_count < LDQ_DEPTH), from registered count only; no same-cycle pass-through when full.
REQ-017 SHALL pop the queue head when it is non-empty and no ALU write (alu_valid && alu_rd!=0) occurs that cycle, producing the write in the next cycle; uncontended load latency = 2 cycles.
REQ-018 SHALL allow push and pop in the same cycle, count unchanged; pointers wrap modulo LDQ_DEPTH.
REQ-019 SHALL discard results with rd=0 (ALU or load): no write, load still consumes a handshake and no queue slot.
REQ-020 SHALL keep ld_valid with ld_ready=0 a no-op; queue and count unchanged.
REQ-021 SHALL hold an 8-bit pending scoreboard: iss_valid && iss_rd!=0 sets pending[iss_rd]; a write issued on the port (wr_en=1) clears pending[wr_addr] on the next edge.
REQ-022 SHALL let set win over clear when both target the same register in one cycle; pending[0] SHALL always read 0.
REQ-023 SHALL drive busy_a = pending[rd_addr_a], busy_b = pending[rd_addr_b], combinationally.
REQ-024 SHALL keep write order per source; ALU and load writes to the same register commit in arbitration order.

Reset
REQ-025 SHALL, on rst_n=0, immediately clear wr_en, wr_addr, wr_data, pending, queue pointers and ldq_count (ld_ready=1).
REQ-026 SHALL discard queued loads on reset mid-operation; no write emerges after rst_n deasserts until new input.

Configuration
REQ-027 SHALL support macro WB_BYPASS_EN: when defined, fwd_x_valid = wr_en && wr_addr==rd_addr_x && rd_addr_x!=0, fwd_x_data = wr_data, and busy_x SHALL be 0 whenever fwd_x_valid=1.
REQ-028 SHALL, when WB_BYPASS_EN is undefined, tie fwd_*_valid and fwd_*_data to 0, busy_x unmodified.

Verification
REQ-029 SHALL cover: alu_valid, alu_rd=3, alu_data=0x5A at N -> wr_en=1, wr_addr=3, wr_data=0x5A at N+1 only.
REQ-030 SHALL cover: ld rd=5 data=0x11 and ALU rd=2 data=0x22 same cycle N -> rd2 write at N+1, rd5 write at N+2.
REQ-031 SHALL cover: alu_valid held with rd!=0 while 3 loads offered, LDQ_DEPTH=2 -> ld_ready=0 after 2 accepts, ldq_count=2, third held until ALU idle.
REQ-032 SHALL cover: iss rd=4 -> busy for rd_addr_a=4 =1; write to 4 -> busy=0 next cycle; iss rd=4 same cycle as write to 4 -> busy stays 1.
REQ-033 SHALL cover: result rd=0 data=0xFF (ALU and load) -> wr_en stays 0, ldq_count unchanged.
REQ-034 SHALL cover: WB_BYPASS_EN with wr_addr=6 wr_data=0x3C and rd_addr_b=6 -> fwd_b_valid=1, fwd_b_data=0x3C, busy_b=0; reset asserted with 2 queued loads -> count=0, no writes.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU-priority write arbitration, a small
// load-result queue, and a pending-write scoreboard. Optional bypass: WB_BYPASS_EN.
module reg_wb_ctrl #(
  parameter int LDQ_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_valid,
  input  logic [2:0]                   alu_rd,
  input  logic [7:0]                   alu_data,
  input  logic                         ld_valid,
  input  logic [2:0]                   ld_rd,
  input  logic [7:0]                   ld_data,
  output logic                         ld_ready,
  input  logic                         iss_valid,
  input  logic [2:0]                   iss_rd,
  input  logic [2:0]                   rd_addr_a,
  input  logic [2:0]                   rd_addr_b,
  output logic                         busy_a,
  output logic                         busy_b,
  output logic                         fwd_a_valid,
  output logic [7:0]                   fwd_a_data,
  output logic                         fwd_b_valid,
  output logic [7:0]                   fwd_b_data,
  output logic                         wr_en,
  output logic [2:0]                   wr_addr,
  output logic [7:0]                   wr_data,
  output logic [$clog2(LDQ_DEPTH):0]   ldq_count
);

  localparam int AW = $clog2(LDQ_DEPTH);
  localparam int CW = AW + 1;

  // Load handshake: a load transfers on a cycle where ld_valid && ld_ready.
  // ld_ready comes from the registered count only, so a full queue never
  // accepts even when it pops that same cycle. ALU results have no back-pressure.

  logic [10:0]   ldq_mem_q [LDQ_DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [2:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    pending_q, pending_d;

  logic          alu_wr;
  logic          ld_accept;
  logic          push;
  logic          pop;
  logic [10:0]   head_entry;

  assign ld_ready   = (count_q < CW'(LDQ_DEPTH));
  assign alu_wr     = alu_valid && (alu_rd != 3'd0);
  assign ld_accept  = ld_valid && ld_ready;
  // rd=0 loads complete the handshake but never occupy a slot.
  assign push       = ld_accept && (ld_rd != 3'd0);
  assign pop        = (count_q != '0) && !alu_wr;
  assign head_entry = ldq_mem_q[head_q];

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = head_entry[10:8];
      wr_data_d = head_entry[7:0];
    end
    if (pop)  head_d = head_q + AW'(1);
    if (push) tail_d = tail_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set beats clear when an issue and a write target the same register.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) pending_d[wr_addr_q] = 1'b0;
    if (iss_valid && (iss_rd != 3'd0)) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ldq_mem_q[tail_q] <= {ld_rd, ld_data};
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign ldq_count = count_q;

`ifdef WB_BYPASS_EN
  // A register being written this cycle is forwarded rather than reported busy.
  assign fwd_a_valid = wr_en_q && (wr_addr_q == rd_addr_a) && (rd_addr_a != 3'd0);
  assign fwd_b_valid = wr_en_q && (wr_addr_q == rd_addr_b) && (rd_addr_b != 3'd0);
  assign fwd_a_data  = wr_data_q;
  assign fwd_b_data  = wr_data_q;
  assign busy_a      = pending_q[rd_addr_a] && !fwd_a_valid;
  assign busy_b      = pending_q[rd_addr_b] && !fwd_b_valid;
`else
  assign fwd_a_valid = 1'b0;
  assign fwd_b_valid = 1'b0;
  assign fwd_a_data  = 8'd0;
  assign fwd_b_data  = 8'd0;
  assign busy_a      = pending_q[rd_addr_a];
  assign busy_b      = pending_q[rd_addr_b];
`endif

endmodule
